synch_down_counter: RTL and testbench
=====================================

Name: synch_down_counter

Overview:
Programmable synchronous down counter and timer. It is the counterpart to the team's synchronous up counter. It is loaded with a start value and decrements once per enabled clock. On reaching the end of its count it raises a terminal-count pulse. It either stops (one-shot) or reloads itself (periodic). It serves as the tick and timeout generator alongside the up counters in the counter library.

Parameters:
n, 4, counter width in bits; count range 1 .. 2^n-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
load  input  1  synchronous load strobe; highest priority after reset.
load_value  input  n  start value, captured on load.
en  input  1  count enable; the counter decrements only on edges where en=1.
auto_reload  input  1  mode select: 1 = periodic, 0 = one-shot. Sampled at the terminal edge.
Q  output  n  current count, registered.
tc  output  1  terminal-count pulse; high for exactly one clk cycle.
busy  output  1  high while in RUN.
done  output  1  high in DONE (one-shot finished) until the next load.

Behaviour:
- Reset (async, reset=1): Q=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. Takes effect without a clock edge. Reset mid-count discards the count; no tc is generated.
- Internal state: reload register (n bits) and state machine IDLE / RUN / DONE.
- busy = (state==RUN) and done = (state==DONE). Both are decoded from registered state, so there is no combinational path from the inputs.
- Priority on each rising edge: reset, then load, then count.
- load=1, load_value != 0:
  - Q <= load_value, reload register <= load_value.
  - state <= RUN, tc <= 0.
  - Applies from any state, including RUN at the terminal edge; load wins and no tc is generated.
- load=1, load_value == 0:
  - Q <= 0, state <= IDLE, tc <= 0, done <= 0.
  - Zero is not a legal count.
- RUN, en=1, Q > 1: Q <= Q-1, tc <= 0.
- RUN, en=1, Q == 1 (terminal edge): tc <= 1, then
  - auto_reload=1: Q <= reload register; state stays RUN. Q never shows 0. Period is exactly load_value enabled edges.
  - auto_reload=0: Q <= 0, state <= DONE.
- RUN, en=0: Q holds, tc <= 0. Enable gaps stretch the count but never lose or add a decrement.
- IDLE and DONE: Q holds at 0, en is ignored, tc=0.
  - DONE exits only on load or reset.
- tc timing:
  - Registered; asserted in the cycle immediately after the terminal edge.
  - In one-shot mode it coincides with Q==0 and done rising.
  - In periodic mode it coincides with Q==reload value.
  - Never high for two consecutive cycles unless load_value==1 with auto_reload=1 and en held high. In that case tc is high every cycle, which is legal.
- Wrap-around: no underflow past 0 is possible; the count never goes below 1 in RUN.
- Maximum count: 2^n-1, which is 15 for n=4.
- All arithmetic is unsigned, n bits.

Test Plan:
1. Async reset: load 9, count 3 edges (Q=6), assert reset between clock edges -> Q=0, busy=0, tc=0 before the next edge; no tc afterwards.
2. One-shot: auto_reload=0, load 5, en=1 -> Q sequence 5,4,3,2,1,0. tc=1 for exactly one cycle, aligned with Q=0. done=1, busy=0. Q stays 0 for 10 further enabled edges.
3. Periodic: auto_reload=1, load 3, en=1 for 10 edges -> Q sequence 3,2,1,3,2,1,3,2,1,3. tc high in exactly the cycles where Q returned to 3. busy stays 1.
4. Enable gating: load 4, en alternating 1/0 -> Q decrements only on en=1 edges. tc occurs after the 4th enabled edge (8 clocks). Q is held unchanged during en=0.
5. Load collision at terminal edge: Q=1, en=1, load=1, load_value=7 -> Q=7, tc=0, state RUN. Then load 0 -> Q=0, busy=0, done=0, and tc never asserts with en high.
6. Full range: n=4, load 15, one-shot, en=1 -> exactly 15 enabled edges to Q=0, with one tc pulse.

Source files
------------

// File: rtl/synch_down_counter.sv
// Programmable synchronous down counter / timer with one-shot and periodic modes.
// Terminal count is a registered one-cycle pulse; busy/done decode the state register.
module synch_down_counter #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] load_value,
    input  logic         en,
    input  logic         auto_reload,
    output logic [n-1:0] Q,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    state_t       state, state_next;
    logic [n-1:0] reload, reload_next;
    logic [n-1:0] q_next;
    logic         tc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            Q      <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state  <= state_next;
            Q      <= q_next;
            reload <= reload_next;
            tc     <= tc_next;
        end
    end

    always_comb begin
        state_next  = state;
        q_next      = Q;
        reload_next = reload;
        tc_next     = 1'b0;

        if (load) begin
            // A zero start value is not a legal count, so it parks the counter in IDLE.
            if (load_value != '0) begin
                q_next      = load_value;
                reload_next = load_value;
                state_next  = RUN;
            end else begin
                q_next     = '0;
                state_next = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (Q > ONE) begin
                            q_next = Q - ONE;
                        end else begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                q_next = reload;
                            end else begin
                                q_next     = '0;
                                state_next = DONE;
                            end
                        end
                    end
                end
                default: begin
                    q_next = '0;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_synch_down_counter.sv
// Directed, table-driven bench for synch_down_counter (n=4) with hand-written
// sequences for async reset and the full-range one-shot count.
module tb_synch_down_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [N-1:0] load_value;
    logic         en;
    logic         auto_reload;
    logic [N-1:0] Q;
    logic         tc;
    logic         busy;
    logic         done;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic         ld;
        logic [N-1:0] lv;
        logic         en;
        logic         ar;
        logic [N-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t vecs[$];

    synch_down_counter #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .auto_reload(auto_reload),
        .Q          (Q),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input int q, input int t, input int b, input int d);
        check({tag, "_q"}, int'(Q), q);
        check({tag, "_tc"}, int'(tc), t);
        check({tag, "_busy"}, int'(busy), b);
        check({tag, "_done"}, int'(done), d);
    endtask

    task automatic add(input logic ld, input int lv, input logic e, input logic ar,
                       input int q, input logic t, input logic b, input logic d);
        vec_t v;
        v.ld = ld; v.lv = lv[N-1:0]; v.en = e; v.ar = ar;
        v.q = q[N-1:0]; v.tc = t; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tc_count;

        reset = 1'b1; load = 1'b0; load_value = '0; en = 1'b0; auto_reload = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0);

        // Test 1: async reset mid-count
        @(negedge clk);
        reset = 1'b0;
        load = 1'b1; load_value = 4'd9; en = 1'b1;
        tick();
        load = 1'b0;
        check("t1_load_q", int'(Q), 9);
        for (int i = 1; i <= 3; i++) tick();
        check_all("t1_pre", 6, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all("t1_async", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all($sformatf("t1_after%0d", i), 0, 0, 0, 0);
        end

        // Test 2: one-shot, load 5
        add(1, 5, 1, 0, 5, 0, 1, 0);
        add(0, 0, 1, 0, 4, 0, 1, 0);
        add(0, 0, 1, 0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 0, 0, 1);
        // Test 3: periodic, load 3
        add(1, 3, 1, 1, 3, 0, 1, 0);
        for (int r = 0; r < 3; r++) begin
            add(0, 0, 1, 1, 2, 0, 1, 0);
            add(0, 0, 1, 1, 1, 0, 1, 0);
            add(0, 0, 1, 1, 3, 1, 1, 0);
        end
        // Test 4: enable gating, load 4 one-shot
        add(1, 4, 0, 0, 4, 0, 1, 0);
        add(0, 0, 1, 0, 3, 0, 1, 0);
        add(0, 0, 0, 0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 2, 0, 1, 0);
        add(0, 0, 0, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        // load 0 from DONE clears done
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Test 5: load collision at terminal edge, then load 0
        add(1, 3, 1, 0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 7, 1, 0, 7, 0, 1, 0);
        add(0, 0, 1, 0, 6, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0, 0, 0, 0);
        // Periodic with load_value 1: tc every cycle
        add(1, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        // auto_reload sampled at the terminal edge: switch to one-shot mid-run
        add(1, 2, 1, 1, 2, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1);

        foreach (vecs[k]) begin
            load = vecs[k].ld; load_value = vecs[k].lv;
            en = vecs[k].en; auto_reload = vecs[k].ar;
            tick();
            check_all($sformatf("row%0d", k), int'(vecs[k].q), int'(vecs[k].tc),
                      int'(vecs[k].busy), int'(vecs[k].done));
        end

        // Test 6: full range one-shot from 15
        load = 1'b1; load_value = 4'd15; en = 1'b1; auto_reload = 1'b0;
        tick();
        load = 1'b0; load_value = '0;
        check_all("t6_load", 15, 0, 1, 0);
        tc_count = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (tc) tc_count++;
            if (i < 15) check_all($sformatf("t6_e%0d", i), 15 - i, 0, 1, 0);
            else        check_all("t6_term", 0, 1, 0, 1);
        end
        tick();
        if (tc) tc_count++;
        check_all("t6_hold", 0, 0, 0, 1);
        check("t6_tc_pulses", tc_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
